// File: rtl/sram_controller.sv
// Bridges cache line reads (64b) and word write-throughs (32b) onto a 16-bit async SRAM.
// Every access is split into halfword slots of ACC_CYCLES clocks each.
module sram_controller #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] address,
  input  logic [31:0] wdata,
  input  logic        sram_r_en,
  input  logic        sram_w_en,
  output logic [63:0] rdata,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    k;
  logic [CW-1:0] cnt;
  logic [17:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [47:0]   line_buf;
  logic          last_cnt;
  logic          dq_en;
  logic [15:0]   dq_out;

  assign last_cnt = (cnt == CW'(ACC_CYCLES - 1));
  assign ready    = (state == DONE);
  assign SRAM_DQ  = dq_en ? dq_out : 16'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      line_buf <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          k   <= '0;
          cnt <= '0;
          if (sram_w_en || sram_r_en) begin
            addr_q  <= address[17:2];
            wdata_q <= wdata;
            state   <= sram_w_en ? WRITE : READ;
          end
        end
        READ: begin
          if (last_cnt) begin
            cnt <= '0;
            k   <= k + 2'd1;
            // Only the final halfword commits the line, so an aborted read never leaks.
            case (k)
              2'd0:    line_buf[15:0]  <= SRAM_DQ;
              2'd1:    line_buf[31:16] <= SRAM_DQ;
              2'd2:    line_buf[47:32] <= SRAM_DQ;
              default: begin
                rdata <= {SRAM_DQ, line_buf};
                state <= DONE;
              end
            endcase
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: begin
          if (last_cnt) begin
            cnt <= '0;
            k   <= k + 2'd1;
            if (k[0]) state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_CE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_en     = 1'b0;
    dq_out    = '0;
    case (state)
      READ: begin
        SRAM_ADDR = {1'b0, addr_q[17:3], k};
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
      WRITE: begin
        SRAM_ADDR = {1'b0, addr_q[17:2], k[0]};
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        // WE_N rises in the last slot so address/data are held past the write edge.
        SRAM_WE_N = last_cnt;
        dq_en     = 1'b1;
        dq_out    = k[0] ? wdata_q[31:16] : wdata_q[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: stimulus pushes expected completions and
// SRAM writes; a monitor pops and compares them as the DUT presents them.
module tb_sram_controller;

  localparam int ACC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] address;
  logic [31:0] wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  sram_controller #(.ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .rdata(rdata), .ready(ready),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(sram_we_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM model: small array covering the addresses used here
  logic [15:0] mem [0:511];
  logic        model_en;
  assign model_en = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq  = model_en ? mem[sram_addr[8:0]] : 16'bz;

  typedef struct { logic [63:0] rdata; int cyc; } rexp_t;
  typedef struct { logic [17:0] a; logic [15:0] d; } wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: completions and SRAM write strobes
  initial begin
    logic  prev_we;
    int    low;
    rexp_t e;
    wexp_t w;
    prev_we = 1'b1;
    low = 0;
    forever begin
      @(negedge clk);
      if (ready) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready: actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = rq.pop_front();
          chk("ready_rdata", rdata, e.rdata);
          chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (!sram_we_n) begin
        low++;
      end else if (!prev_we) begin
        mem[sram_addr[8:0]] = sram_dq;
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual addr=0x%0h required none", sram_addr);
        end else begin
          w = wq.pop_front();
          chk("write_addr", 64'(sram_addr), 64'(w.a));
          chk("write_data", 64'(sram_dq), 64'(w.d));
          chk("we_low_cycles", 64'(low), 64'(ACC - 1));
        end
        low = 0;
      end
      prev_we = sram_we_n;
    end
  end

  task automatic issue(input logic w, input logic r, input logic [17:0] a,
                       input logic [31:0] d, output int t);
    @(negedge clk);
    sram_w_en = w;
    sram_r_en = r;
    address   = a;
    wdata     = d;
    t = cyc;
  endtask

  task automatic drop_en();
    @(negedge clk);
    sram_w_en = 1'b0;
    sram_r_en = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL timeout: actual pending=%0d required 0", rq.size() + wq.size());
      rq.delete();
      wq.delete();
    end
  endtask

  task automatic chk_idle(input string name, input logic [63:0] exp_rdata);
    chk({name, "_ready"}, 64'(ready), 64'd0);
    chk({name, "_rdata"}, rdata, exp_rdata);
    chk({name, "_addr"}, 64'(sram_addr), 64'd0);
    chk({name, "_ctl_n"}, 64'({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}), 64'h1f);
  endtask

  localparam logic [63:0] LINE84 = 64'h4444_3333_2222_1111;

  initial begin
    int t;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    mem[9'h80] = 16'hAAAA;
    mem[9'h81] = 16'hBBBB;
    mem[9'h84] = 16'h1111;
    mem[9'h85] = 16'h2222;
    mem[9'h86] = 16'h3333;
    mem[9'h87] = 16'h4444;
    rst = 1'b1;
    address = '0;
    wdata = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle("post_reset", 64'd0);

    // 1: reset for 2 cycles in the middle of a read
    issue(1'b0, 1'b1, 18'h0010C, 32'h0, t);
    drop_en();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset1", 64'd0);
    @(negedge clk);
    chk_idle("mid_reset2", 64'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk_idle("after_reset", 64'd0);

    // 2: word write
    issue(1'b1, 1'b0, 18'h00104, 32'h1234_5678, t);
    wq.push_back('{18'h00082, 16'h5678});
    wq.push_back('{18'h00083, 16'h1234});
    rq.push_back('{64'd0, t + 5});
    drop_en();
    wait_done();

    // 3: line read
    issue(1'b0, 1'b1, 18'h0010C, 32'h0, t);
    rq.push_back('{LINE84, t + 9});
    drop_en();
    wait_done();

    // 4: both enables -> write only, rdata kept
    issue(1'b1, 1'b1, 18'h00104, 32'h9ABC_DEF0, t);
    wq.push_back('{18'h00082, 16'hDEF0});
    wq.push_back('{18'h00083, 16'h9ABC});
    rq.push_back('{LINE84, t + 5});
    drop_en();
    wait_done();

    // 5: reset during cycle 4 of a read, then a clean read
    issue(1'b0, 1'b1, 18'h0010C, 32'h0, t);
    drop_en();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("abort_read", 64'd0);
    repeat (12) @(negedge clk);
    issue(1'b0, 1'b1, 18'h0010C, 32'h0, t);
    rq.push_back('{LINE84, t + 9});
    drop_en();
    wait_done();

    // 6: inputs change mid-write; read enable held into the following IDLE
    issue(1'b1, 1'b1, 18'h00200, 32'hCAFE_F00D, t);
    wq.push_back('{18'h00100, 16'hF00D});
    wq.push_back('{18'h00101, 16'hCAFE});
    rq.push_back('{LINE84, t + 5});
    rq.push_back('{64'h9ABC_DEF0_BBBB_AAAA, t + 15});
    @(negedge clk);
    sram_w_en = 1'b0;
    address   = 18'h00100;
    wdata     = 32'hDEAD_BEEF;
    repeat (6) @(negedge clk);
    sram_r_en = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk_idle("final_idle", 64'h9ABC_DEF0_BBBB_AAAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
